// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM time-slot arbiter.
//   owner_e            : which requester drives the RAM bus in a given cycle
//   VGA_BASE_DEFAULT   : upper address bits of the video window ($C000-$DFFF)
//   STARVE_MAX_DEFAULT : denied odd slots tolerated before DMA is forced in
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OwnIdle = 2'd0,
      OwnCpu  = 2'd1,
      OwnVga  = 2'd2,
      OwnDma  = 2'd3
   } owner_e;

   localparam logic [2:0]  VGA_BASE_DEFAULT   = 3'b110;
   localparam int unsigned STARVE_MAX_DEFAULT = 15;

endpackage

// File: rtl/ram_arbiter.sv
// Time-slot arbiter for the single-port synchronous video/work RAM.
// Even cycles (phase=0) always belong to the CPU; odd cycles (phase=1) are shared
// between VGA scanout and the DMA/blitter port, with a starvation guard for DMA.
//
// Ports:
//   clk, rst                    : 25.175 MHz clock, async active-high reset
//   phase                       : slot phase, 0 = CPU slot, 1 = shared slot (CPU clock)
//   cpu_addr/dbw/we/sel         : CPU request side
//   cpu_dbr                     : CPU read data, latched at end of the phase-1 cycle
//   vga_req/vga_addr            : VGA fetch request for the next shared slot
//   vga_data/vga_valid          : VGA read return, one cycle after the slot
//   vga_miss                    : VGA slot stolen by the starvation guard
//   dma_req/addr/dbw/we         : DMA request, held until dma_ack
//   dma_ack                     : DMA access occurring this cycle
//   dma_dbr/dma_valid           : DMA read data (latched) and its update pulse
//   ram_addr/dbw/we, ram_dbr    : RAM port, one-cycle read latency
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned       AW         = 16,
   parameter int unsigned       DW         = 8,
   parameter int unsigned       VAW        = 13,
   parameter logic [AW-VAW-1:0] VGA_BASE   = VGA_BASE_DEFAULT,
   parameter int unsigned       STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   output logic           phase,
   input  logic [AW-1:0]  cpu_addr,
   input  logic [DW-1:0]  cpu_dbw,
   input  logic           cpu_we,
   input  logic           cpu_sel,
   output logic [DW-1:0]  cpu_dbr,
   input  logic           vga_req,
   input  logic [VAW-1:0] vga_addr,
   output logic [DW-1:0]  vga_data,
   output logic           vga_valid,
   output logic           vga_miss,
   input  logic           dma_req,
   input  logic [AW-1:0]  dma_addr,
   input  logic [DW-1:0]  dma_dbw,
   input  logic           dma_we,
   output logic           dma_ack,
   output logic [DW-1:0]  dma_dbr,
   output logic           dma_valid,
   output logic [AW-1:0]  ram_addr,
   output logic [DW-1:0]  ram_dbw,
   output logic           ram_we,
   input  logic [DW-1:0]  ram_dbr
);

   localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

   logic          phase_q, phase_next;
   owner_e        owner_q, owner_next;
   owner_e        owner_dly_q;
   logic [3:0]    starve_q, starve_next;
   logic          vga_miss_q, vga_miss_next;
   logic          dma_we_dly_q;
   logic [DW-1:0] cpu_dbr_q, dma_dbr_q;
   logic          dma_valid_q;
   logic [AW-1:0] vga_win_addr;

   assign vga_win_addr = {VGA_BASE, vga_addr};

   // Owner and starvation bookkeeping for the cycle that follows.
   always_comb begin
      phase_next    = ~phase_q;
      owner_next    = OwnIdle;
      starve_next   = starve_q;
      vga_miss_next = 1'b0;
      if (!phase_next) begin
         owner_next = OwnCpu;
      end else begin
         if (dma_req && (starve_q == StarveLim)) begin
            owner_next    = OwnDma;
            vga_miss_next = vga_req;
         end else if (vga_req && (starve_q < StarveLim)) begin
            owner_next = OwnVga;
         end else if (dma_req) begin
            owner_next = OwnDma;
         end
         if (owner_next == OwnDma) begin
            starve_next = '0;
         end else if (dma_req && (starve_q != 4'hF)) begin
            starve_next = starve_q + 4'd1;
         end
      end
      if (!dma_req) begin
         starve_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= 1'b0;
         owner_q      <= OwnIdle;
         owner_dly_q  <= OwnIdle;
         starve_q     <= '0;
         vga_miss_q   <= 1'b0;
         dma_we_dly_q <= 1'b0;
         cpu_dbr_q    <= 8'hFF;
         dma_dbr_q    <= 8'hFF;
         dma_valid_q  <= 1'b0;
      end else begin
         phase_q      <= phase_next;
         owner_q      <= owner_next;
         owner_dly_q  <= owner_q;
         starve_q     <= starve_next;
         vga_miss_q   <= vga_miss_next;
         dma_we_dly_q <= dma_we;
         // Read returns arrive one cycle after the slot that issued them.
         if (owner_dly_q == OwnCpu) begin
            cpu_dbr_q <= ram_dbr;
         end
         dma_valid_q <= (owner_dly_q == OwnDma) && !dma_we_dly_q;
         if ((owner_dly_q == OwnDma) && !dma_we_dly_q) begin
            dma_dbr_q <= ram_dbr;
         end
      end
   end

   // RAM bus is a pure mux of the registered owner.
   always_comb begin
      ram_addr = vga_win_addr;
      ram_dbw  = '0;
      ram_we   = 1'b0;
      unique case (owner_q)
         OwnCpu: begin
            ram_addr = cpu_addr;
            ram_dbw  = cpu_dbw;
            ram_we   = cpu_we & cpu_sel;
         end
         OwnVga: begin
            ram_addr = vga_win_addr;
         end
         OwnDma: begin
            ram_addr = dma_addr;
            ram_dbw  = dma_dbw;
            ram_we   = dma_we;
         end
         OwnIdle: begin
            ram_addr = vga_win_addr;
         end
      endcase
      // Abort an in-flight write the instant reset asserts, not at the next edge.
      if (rst) begin
         ram_we = 1'b0;
      end
   end

   assign phase     = phase_q;
   assign cpu_dbr   = cpu_dbr_q;
   assign vga_data  = ram_dbr;
   assign vga_valid = (owner_dly_q == OwnVga);
   assign vga_miss  = vga_miss_q;
   assign dma_ack   = (owner_q == OwnDma);
   assign dma_dbr   = dma_dbr_q;
   assign dma_valid = dma_valid_q;

endmodule
